lcd_scan: RTL and testbench
===========================

// Module: lcd_scan
// PURPOSE
//  Read side of the VRAM buffer filled by the Z88 screen fetcher. Generates 640x480@60
//  raster timing and reads the 640x64 Z88 LCD image from the VRAM read port.
//  Each LCD row is repeated VSCALE times, inside a vertical window.
//  Drives 12-bit RGB, syncs and blanking to the video DAC.
// PARAMETERS
//  H_VIS 640 / H_FP 16 / H_SYNC 96 / H_BP 48 : horizontal timing, in pixels
//  V_VIS 480 / V_FP 10 / V_SYNC 2 / V_BP 33  : vertical timing, in lines
//  WIN_Y   112     first display line of the LCD window
//  VSCALE  4       display lines per LCD row; must be a power of 2
//  FG      12'hFFF colour of a lit pixel
//  BG      12'h214 colour of an unlit pixel, and of the whole window when the LCD is off
//  BORDER  12'h000 colour of visible area outside the window
// PORTS
//  mck      in  1   system clock
//  rin      in  1   reset, synchronous, active-high
//  pix_en   in  1   pixel clock enable; one pixel per mck cycle with pix_en=1
//  lcdon    in  1   LCD enable from the Blink
//  vram_ra  out 14  VRAM read address; word = row*160 + col/4
//  vram_di  in  4   VRAM read data, valid one mck after vram_ra; bit3 = leftmost pixel
//  rgb      out 12  pixel colour {r4,g4,b4}
//  hsync_n  out 1   horizontal sync, active low
//  vsync_n  out 1   vertical sync, active low
//  de       out 1   visible-area flag
//  vblank   out 1   high while the vertical counter is outside the visible lines
// BEHAVIOUR
//  - Reset values: h=v=0, vram_ra=0, rgb=0, hsync_n=vsync_n=1, de=0, vblank=0.
//    All pipeline stages are cleared. Reset mid-frame restarts at h=v=0 on the next cycle.
//  - Counters advance only when pix_en=1. h runs 0..799; v increments when h wraps and runs 0..524.
//    With pix_en=0 every register holds.
//  - Regions: visible when h<640 and v<480. hsync active for h in 656..751.
//    vsync active for v in 490..491. Window is v in [WIN_Y, WIN_Y+64*VSCALE).
//  - Row base: cleared at v=WIN_Y. Adds 160 each time (v-WIN_Y)%VSCALE wraps.
//    No multiplier is used; the last row base is 63*160 = 10080.
//  - Fetch: each 4-pixel word is read before its first pixel is shifted out.
//    The word is loaded into a 4-bit shift register, which shifts MSB-first one bit per pix_en.
//    Reads never address beyond word 10239.
//  - Fixed output latency PIPE=3 pix_en ticks. hsync_n, vsync_n and de are delayed
//    by exactly PIPE so they align with rgb. The pixel appearing in de-column c is VRAM word
//    rowbase+c/4, bit 3-(c%4).
//  - rgb: de=0 -> 0. In window with lcd_on_f=1 -> FG if the bit is 1, else BG.
//    In window with lcd_on_f=0 -> BG. Visible but outside the window -> BORDER.
//  - lcd_on_f samples lcdon at h=0,v=0 with pix_en=1, so a change takes effect only at frame start.
//  - vblank is undelayed (counter-aligned) so the screen writer can use it to schedule refill.
//  - Changes on vram_di outside the sampling cycle have no effect.
// STRUCTURE
//  - Shared package (z88_video_pkg): the timing constants, LCD_W=640, LCD_H=64, WORDS_PER_ROW=160,
//    and the RGB colour constants.
//  - Sub-module vid_timing: h/v counters, sync, de and vblank generation.
//    lcd_scan holds the window, address, shift and colour logic.
// TESTING
//  - Reset, then 800*525 pix_en ticks -> exactly one vsync pulse of 2 lines, and 525 hsync pulses of 96 px.
//    The first hsync_n fall is PIPE+656 ticks after reset.
//  - VRAM model with word n = n[3:0], lcdon=1 -> line WIN_Y+PIPE-aligned column c equals FG iff
//    bit 3-(c%4) of (c/4)[3:0] is set.
//  - Row stepping, VSCALE=4 -> lines WIN_Y..WIN_Y+3 read base 0, lines WIN_Y+4..+7 read base 160.
//    The last window line reads words 10080..10239. No read address exceeds 10239.
//  - lcdon dropped mid-frame -> the current frame is unchanged. The next frame's window is all BG,
//    the border stays BORDER, and rgb=0 when de=0.
//  - pix_en toggled 1-0-0-1 randomly -> output sequence identical to the pix_en=1 run, with stalls only.
//  - rin asserted at h=300,v=200 for 1 cycle -> the next cycle shows reset values. The frame restarts
//    and the second vsync occurs 525 lines later.

Source files
------------

// File: rtl/z88_video_pkg.sv
// z88_video_pkg: shared 640x480 timing, Z88 LCD geometry and palette.
package z88_video_pkg;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;

  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam int WIN_Y  = 112;
  localparam int VSCALE = 4;

  localparam int LCD_W         = 640;
  localparam int LCD_H         = 64;
  localparam int WORDS_PER_ROW = 160;

  localparam int PIPE = 3;

  localparam logic [11:0] FG     = 12'hFFF;
  localparam logic [11:0] BG     = 12'h214;
  localparam logic [11:0] BORDER = 12'h000;

  typedef logic [9:0]  cnt_t;
  typedef logic [13:0] addr_t;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic win;
    logic ld;
  } stage_t;

endpackage

// File: rtl/vid_timing.sv
// vid_timing: raster h/v counters with sync, visible and vblank flags.
module vid_timing #(
  parameter int H_VIS  = z88_video_pkg::H_VIS,
  parameter int H_FP   = z88_video_pkg::H_FP,
  parameter int H_SYNC = z88_video_pkg::H_SYNC,
  parameter int H_BP   = z88_video_pkg::H_BP,
  parameter int V_VIS  = z88_video_pkg::V_VIS,
  parameter int V_FP   = z88_video_pkg::V_FP,
  parameter int V_SYNC = z88_video_pkg::V_SYNC,
  parameter int V_BP   = z88_video_pkg::V_BP
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output z88_video_pkg::cnt_t h,
  output z88_video_pkg::cnt_t v,
  output z88_video_pkg::cnt_t hn,
  output z88_video_pkg::cnt_t vn,
  output logic                vis,
  output logic                hs,
  output logic                vs,
  output logic                vblank
);
  import z88_video_pkg::cnt_t;

  localparam cnt_t H_MAX =
    cnt_t'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t V_MAX =
    cnt_t'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam cnt_t HV  = cnt_t'(H_VIS);
  localparam cnt_t VV  = cnt_t'(V_VIS);
  localparam cnt_t HS0 = cnt_t'(H_VIS + H_FP);
  localparam cnt_t HS1 = cnt_t'(H_VIS + H_FP + H_SYNC);
  localparam cnt_t VS0 = cnt_t'(V_VIS + V_FP);
  localparam cnt_t VS1 = cnt_t'(V_VIS + V_FP + V_SYNC);

  // next raster position, shared with the fetch lookahead
  always_comb begin
    hn = h + cnt_t'(1);
    vn = v;
    if (h == H_MAX) begin
      hn = '0;
      vn = (v == V_MAX) ? '0 : v + cnt_t'(1);
    end
  end

  assign vis = (h < HV) && (v < VV);
  assign hs  = (h >= HS0) && (h < HS1);
  assign vs  = (v >= VS0) && (v < VS1);

  always_ff @(posedge clk) begin
    if (rst) begin
      h      <= '0;
      v      <= '0;
      vblank <= 1'b0;
    end else if (en) begin
      h      <= hn;
      v      <= vn;
      vblank <= (vn >= VV);
    end
  end

endmodule

// File: rtl/lcd_scan.sv
// lcd_scan: scans the 640x64 LCD image out of VRAM into a
// vertically scaled window of a 640x480@60 raster.
module lcd_scan #(
  parameter int H_VIS  = z88_video_pkg::H_VIS,
  parameter int H_FP   = z88_video_pkg::H_FP,
  parameter int H_SYNC = z88_video_pkg::H_SYNC,
  parameter int H_BP   = z88_video_pkg::H_BP,
  parameter int V_VIS  = z88_video_pkg::V_VIS,
  parameter int V_FP   = z88_video_pkg::V_FP,
  parameter int V_SYNC = z88_video_pkg::V_SYNC,
  parameter int V_BP   = z88_video_pkg::V_BP,
  parameter int WIN_Y  = z88_video_pkg::WIN_Y,
  parameter int VSCALE = z88_video_pkg::VSCALE
) (
  input  logic        mck,
  input  logic        rin,
  input  logic        pix_en,
  input  logic        lcdon,
  output logic [13:0] vram_ra,
  input  logic [3:0]  vram_di,
  output logic [11:0] rgb,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        de,
  output logic        vblank
);
  import z88_video_pkg::cnt_t, z88_video_pkg::addr_t;
  import z88_video_pkg::stage_t, z88_video_pkg::LCD_H;
  import z88_video_pkg::WORDS_PER_ROW;
  import z88_video_pkg::FG, z88_video_pkg::BG;
  import z88_video_pkg::BORDER;

  localparam cnt_t  W0  = cnt_t'(WIN_Y);
  localparam cnt_t  W1  = cnt_t'(WIN_Y + LCD_H * VSCALE);
  localparam cnt_t  SUB = cnt_t'(VSCALE - 1);
  localparam cnt_t  HV  = cnt_t'(H_VIS);
  localparam addr_t ROW = addr_t'(WORDS_PER_ROW);

  cnt_t       h;
  cnt_t       v;
  cnt_t       hn;
  cnt_t       vn;
  logic       vis;
  logic       hact;
  logic       vact;
  addr_t      rb;
  addr_t      rb_nx;
  stage_t     s1;
  stage_t     s2;
  logic [3:0] sh;
  logic       lcd_on_f;

  vid_timing #(
    .H_VIS (H_VIS),
    .H_FP  (H_FP),
    .H_SYNC(H_SYNC),
    .H_BP  (H_BP),
    .V_VIS (V_VIS),
    .V_FP  (V_FP),
    .V_SYNC(V_SYNC),
    .V_BP  (V_BP)
  ) u_tim (
    .clk   (mck),
    .rst   (rin),
    .en    (pix_en),
    .h     (h),
    .v     (v),
    .hn    (hn),
    .vn    (vn),
    .vis   (vis),
    .hs    (hact),
    .vs    (vact),
    .vblank(vblank)
  );

  function automatic logic in_win(cnt_t y);
    return (y >= W0) && (y < W1);
  endfunction

  // row base of the line being entered, stepped once per VSCALE lines
  always_comb begin
    rb_nx = rb;
    if (hn == '0) begin
      if (vn == W0) begin
        rb_nx = '0;
      end else if (in_win(vn) && (((vn - W0) & SUB) == '0)) begin
        rb_nx = rb + ROW;
      end
    end
  end

  always_ff @(posedge mck) begin
    if (rin) begin
      rb       <= '0;
      vram_ra  <= '0;
      lcd_on_f <= 1'b0;
      s1       <= '0;
      s2       <= '0;
      sh       <= '0;
      rgb      <= '0;
      hsync_n  <= 1'b1;
      vsync_n  <= 1'b1;
      de       <= 1'b0;
    end else if (pix_en) begin
      rb <= rb_nx;
      // address the word of the next position so data is back before load
      if (hn < HV) begin
        vram_ra <= rb_nx + addr_t'(hn[9:2]);
      end
      if (h == '0 && v == '0) begin
        lcd_on_f <= lcdon;
      end
      s1 <= '{de:  vis,
              hs:  hact,
              vs:  vact,
              win: in_win(v),
              ld:  (h[1:0] == 2'b00)};
      s2 <= s1;
      sh <= s1.ld ? vram_di : {sh[2:0], 1'b0};
      de      <= s2.de;
      hsync_n <= ~s2.hs;
      vsync_n <= ~s2.vs;
      if (!s2.de) begin
        rgb <= '0;
      end else if (!s2.win) begin
        rgb <= BORDER;
      end else if (lcd_on_f && sh[3]) begin
        rgb <= FG;
      end else begin
        rgb <= BG;
      end
    end
  end

endmodule

// File: tb/tb_lcd_scan.sv
// tb_lcd_scan: random pix_en/lcdon stimulus on a reduced-timing and a
// default instance, scored against a frame-arithmetic reference model.
module tb_lcd_scan;
  import z88_video_pkg::*;

  typedef struct packed {
    int hv; int hf; int hs; int hb;
    int vv; int vf; int vs; int vb;
    int wy; int vsc;
  } cfg_t;

  typedef struct {
    int          k;
    logic [11:0] rgb;
    logic        hs_n;
    logic        vs_n;
    logic        de;
    logic        vb;
  } exp_t;

  localparam cfg_t CS = '{hv: 64, hf: 4, hs: 8, hb: 4,
                          vv: 136, vf: 2, vs: 2, vb: 4,
                          wy: 4, vsc: 2};
  localparam cfg_t CD = '{hv: H_VIS, hf: H_FP, hs: H_SYNC,
                          hb: H_BP, vv: V_VIS, vf: V_FP,
                          vs: V_SYNC, vb: V_BP,
                          wy: WIN_Y, vsc: VSCALE};

  logic        clk;
  logic        rin;
  logic        pix_en;
  logic        lcdon;
  logic [13:0] ra_s, ra_d;
  logic [3:0]  di_s, di_d;
  logic [11:0] rgb_s, rgb_d;
  logic        hs_s, hs_d, vs_s, vs_d;
  logic        de_s, de_d, vb_s, vb_d;

  logic [3:0] mem [0:10239];
  bit         lcd_at [0:65535];
  int         k;
  int         vectors;
  int         miscompares;
  exp_t       q_s[$];
  exp_t       q_d[$];

  lcd_scan #(
    .H_VIS(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VIS(136), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .WIN_Y(4), .VSCALE(2)
  ) u_small (
    .mck(clk), .rin(rin), .pix_en(pix_en), .lcdon(lcdon),
    .vram_ra(ra_s), .vram_di(di_s), .rgb(rgb_s),
    .hsync_n(hs_s), .vsync_n(vs_s), .de(de_s),
    .vblank(vb_s)
  );

  lcd_scan u_def (
    .mck(clk), .rin(rin), .pix_en(pix_en), .lcdon(lcdon),
    .vram_ra(ra_d), .vram_di(di_d), .rgb(rgb_d),
    .hsync_n(hs_d), .vsync_n(vs_d), .de(de_d),
    .vblank(vb_d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // synchronous-read VRAM: data one mck after the address
  always @(posedge clk) begin
    di_s <= mem[ra_s];
    di_d <= mem[ra_d];
  end

  // expected outputs after kk pix_en ticks since reset
  function automatic exp_t model(cfg_t c, int kk);
    exp_t e;
    int   ht, f, p, h, v, w;
    bit   on;
    ht = c.hv + c.hf + c.hs + c.hb;
    f  = ht * (c.vv + c.vf + c.vs + c.vb);
    e.k    = kk;
    e.rgb  = '0;
    e.hs_n = 1'b1;
    e.vs_n = 1'b1;
    e.de   = 1'b0;
    e.vb   = ((kk % f) / ht) >= c.vv;
    if (kk >= PIPE) begin
      p = (kk - PIPE) % f;
      h = p % ht;
      v = p / ht;
      e.hs_n = !(h >= c.hv + c.hf && h < c.hv + c.hf + c.hs);
      e.vs_n = !(v >= c.vv + c.vf && v < c.vv + c.vf + c.vs);
      e.de   = (h < c.hv) && (v < c.vv);
      if (e.de) begin
        if (v >= c.wy && v < c.wy + LCD_H * c.vsc) begin
          w  = ((v - c.wy) / c.vsc) * WORDS_PER_ROW + h / 4;
          on = lcd_at[((kk - PIPE) / f) * f];
          e.rgb = (on && mem[w][3 - h % 4]) ? FG : BG;
        end else begin
          e.rgb = BORDER;
        end
      end
    end
    return e;
  endfunction

  task automatic check(input string nm, input exp_t e,
                       input logic [11:0] rgb,
                       input logic hs, input logic vs,
                       input logic d, input logic vb,
                       input logic [13:0] ra);
    vectors++;
    if (rgb !== e.rgb || hs !== e.hs_n || vs !== e.vs_n ||
        d !== e.de || vb !== e.vb || ra > 14'd10239) begin
      miscompares++;
      $display({"FAIL %s k=%0d got rgb=%h hs_n=%b vs_n=%b",
                " de=%b vb=%b ra=%0d want rgb=%h hs_n=%b",
                " vs_n=%b de=%b vb=%b ra<=10239"},
               nm, e.k, rgb, hs, vs, d, vb, ra,
               e.rgb, e.hs_n, e.vs_n, e.de, e.vb);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (q_s.size() > 0)
        check("small", q_s.pop_front(),
              rgb_s, hs_s, vs_s, de_s, vb_s, ra_s);
      while (q_d.size() > 0)
        check("default", q_d.pop_front(),
              rgb_d, hs_d, vs_d, de_d, vb_d, ra_d);
    end
  end

  task automatic step(input bit r, input bit pe, input bit lo);
    @(negedge clk);
    rin    = r;
    pix_en = pe;
    lcdon  = lo;
    @(posedge clk);
    if (r) begin
      k = 0;
    end else if (pe && k < 65535) begin
      lcd_at[k] = lo;
      k++;
    end
    if (r || pe) begin
      q_s.push_back(model(CS, k));
      q_d.push_back(model(CD, k));
    end
  endtask

  initial begin
    rin = 1'b1;
    pix_en = 1'b0;
    lcdon = 1'b1;
    k = 0;
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 10240; i++) mem[i] = 4'($urandom);
    step(1, 0, 1);
    step(1, 1, 1);
    step(1, 0, 1);
    // lcdon dropped inside frame 0's window, back in frame 1
    while (k < 19550)
      step(0, 1, (k < 6000) || (k >= 14000));
    // reset at h=30, v=100 of the second frame
    step(1, 1, 1);
    for (int c = 0; c < 40000; c++)
      step(0, $urandom_range(0, 9) < 6,
           (c < 12000) || (c >= 30000));
    step(0, 0, 1);
    step(0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
